led_shift_engine: RTL and testbench

Pattern engine that consumes the one-cycle shift-enable tick produced by the rate counter and drives the LED bank. Each rising edge of the tick advances the LED pattern by one step in the selected mode: rotate left, rotate right, ping-pong or flash. It sits directly downstream of the counter, with its output going to the board LEDs.

---
 rtl/led_shift_engine_if.sv | 11 +
 rtl/led_shift_engine.sv | 68 ++++++
 tb/tb_led_shift_engine.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/led_shift_engine_if.sv
// led_shift_engine_if: step/mode inputs (i_shift_enable, i_run, i_mode) and LED outputs (o_led, o_dir, o_wrap); master drives the inputs, slave is the engine
interface led_shift_engine_if #(parameter int NB_LEDS = 4);
  logic               i_shift_enable;
  logic               i_run;
  logic [1:0]         i_mode;
  logic [NB_LEDS-1:0] o_led;
  logic               o_dir;
  logic               o_wrap;
  modport master (output i_shift_enable, i_run, i_mode, input o_led, o_dir, o_wrap);
  modport slave (input i_shift_enable, i_run, i_mode, output o_led, o_dir, o_wrap);
endinterface

// File: rtl/led_shift_engine.sv
// led_shift_engine: steps the LED pattern (rotate L/R, ping-pong, flash) on each rising edge of the shift tick; ports clk, i_ck_reset (sync, active-high), bus.slave (i_shift_enable, i_run, i_mode in; o_led, o_dir, o_wrap registered out)
module led_shift_engine #(
  parameter int NB_LEDS = 4
) (
  input  logic              clk,
  input  logic              i_ck_reset,
  led_shift_engine_if.slave bus
);
  localparam logic [NB_LEDS-1:0] ONE = NB_LEDS'(1);
  localparam logic [NB_LEDS-1:0] MSB = ONE << (NB_LEDS - 1);
  logic [1:0]         r_mode;
  logic               r_prev_en;
  logic               r_dir;
  logic [NB_LEDS-1:0] r_led;
  logic               r_wrap;
  logic               w_step;
  logic               w_reload;
  logic               w_onehot;
  logic [NB_LEDS-1:0] w_seed;
  logic [NB_LEDS-1:0] w_cur_seed;
  logic [NB_LEDS-1:0] w_pp;
  logic [NB_LEDS-1:0] w_nled;
  logic               w_ndir;
  logic               w_nwrap;
  always_comb begin
    w_step     = bus.i_shift_enable & ~r_prev_en & bus.i_run;
    w_reload   = bus.i_mode != r_mode;
    w_onehot   = (r_led != '0) && ((r_led & (r_led - ONE)) == '0);
    w_seed     = bus.i_mode == 2'b01 ? MSB : bus.i_mode == 2'b11 ? '1 : ONE;
    w_cur_seed = r_mode == 2'b01 ? MSB : ONE;
    w_pp       = r_dir ? r_led >> 1 : r_led << 1;
    w_nled     = r_mode == 2'b11 ? (r_led == '1 ? '0 : '1) :
                 !w_onehot ? w_cur_seed :
                 r_mode == 2'b00 ? {r_led[NB_LEDS-2:0], r_led[NB_LEDS-1]} :
                 r_mode == 2'b01 ? {r_led[0], r_led[NB_LEDS-1:1]} : w_pp;
    w_ndir     = (r_mode == 2'b10 && w_onehot) ? (r_dir ? w_pp != ONE : w_pp == MSB) : 1'b0;
    w_nwrap    = r_mode == 2'b11 ? r_led == '0 :
                 w_onehot && (r_mode == 2'b00 ? r_led == MSB :
                              r_mode == 2'b01 ? r_led == ONE :
                              (r_dir && r_led == (ONE << 1)));
  end
  always_ff @(posedge clk) begin
    if (i_ck_reset) begin
      r_mode    <= 2'b00;
      r_prev_en <= 1'b0;
      r_dir     <= 1'b0;
      r_led     <= ONE;
      r_wrap    <= 1'b0;
    end else begin
      r_prev_en <= bus.i_shift_enable;
      if (w_reload) begin
        r_mode <= bus.i_mode;
        r_led  <= w_seed;
        r_dir  <= 1'b0;
        r_wrap <= 1'b0;
      end else begin
        r_wrap <= w_step & w_nwrap;
        if (w_step) begin
          r_led <= w_nled;
          r_dir <= w_ndir;
        end
      end
    end
  end
  assign bus.o_led  = r_led;
  assign bus.o_dir  = r_dir;
  assign bus.o_wrap = r_wrap;
endmodule

// File: tb/tb_led_shift_engine.sv
// tb_led_shift_engine: directed self-checking bench for led_shift_engine with NB_LEDS = 4
module tb_led_shift_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  led_shift_engine_if #(.NB_LEDS(4)) bus ();
  led_shift_engine #(.NB_LEDS(4)) dut (.clk(clk), .i_ck_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse();
    bus.i_shift_enable = 1'b1;
    tick();
    bus.i_shift_enable = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.i_shift_enable = 1'b0;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    bus.i_shift_enable = 1'b0;
    bus.i_run = 1'b1;
    bus.i_mode = 2'b00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if (bus.o_led !== 4'b0001) begin fails++; $display("FAIL reset_led got %b want 0001", bus.o_led); end
    tests++;
    if (bus.o_dir !== 1'b0 || bus.o_wrap !== 1'b0) begin fails++; $display("FAIL reset_flags got dir=%b wrap=%b want 0 0", bus.o_dir, bus.o_wrap); end
    tick();
    tests++;
    if (bus.o_led !== 4'b0001) begin fails++; $display("FAIL reset_idle got %b want 0001", bus.o_led); end
  endtask
  task automatic test_rotate_left();
    logic [3:0] exp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      pulse();
      tests++;
      if (bus.o_led !== exp[i] || bus.o_wrap !== (i == 3)) begin
        fails++; $display("FAIL rotl_step%0d got led=%b wrap=%b want led=%b wrap=%b", i, bus.o_led, bus.o_wrap, exp[i], i == 3);
      end
      tick();
      tests++;
      if (bus.o_wrap !== 1'b0 || bus.o_led !== exp[i]) begin
        fails++; $display("FAIL rotl_hold%0d got led=%b wrap=%b want led=%b wrap=0", i, bus.o_led, bus.o_wrap, exp[i]);
      end
      tick();
      tick();
    end
  endtask
  task automatic test_held_enable();
    do_reset();
    bus.i_shift_enable = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    tests++;
    if (bus.o_led !== 4'b0010) begin fails++; $display("FAIL held_one_step got %b want 0010", bus.o_led); end
    bus.i_shift_enable = 1'b0;
    tick();
    pulse();
    tests++;
    if (bus.o_led !== 4'b0100) begin fails++; $display("FAIL back_to_back got %b want 0100", bus.o_led); end
    tick();
  endtask
  task automatic test_ping_pong();
    logic [3:0] exp_led [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic       exp_dir [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bus.i_mode = 2'b10;
    tick();
    tests++;
    if (bus.o_led !== 4'b0001 || bus.o_dir !== 1'b0) begin
      fails++; $display("FAIL pp_reload got led=%b dir=%b want 0001 0", bus.o_led, bus.o_dir);
    end
    for (int i = 0; i < 7; i++) begin
      pulse();
      tests++;
      if (bus.o_led !== exp_led[i] || bus.o_dir !== exp_dir[i] || bus.o_wrap !== (i == 5)) begin
        fails++; $display("FAIL pp_step%0d got led=%b dir=%b wrap=%b want led=%b dir=%b wrap=%b",
                          i, bus.o_led, bus.o_dir, bus.o_wrap, exp_led[i], exp_dir[i], i == 5);
      end
      tick();
      tests++;
      if (bus.o_wrap !== 1'b0) begin fails++; $display("FAIL pp_wrap_clear%0d got %b want 0", i, bus.o_wrap); end
    end
  endtask
  task automatic test_mode_change();
    bus.i_mode = 2'b00;
    do_reset();
    pulse(); tick();
    pulse(); tick();
    tests++;
    if (bus.o_led !== 4'b0100) begin fails++; $display("FAIL mc_setup got %b want 0100", bus.o_led); end
    bus.i_shift_enable = 1'b1;
    bus.i_mode = 2'b01;
    tick();
    tests++;
    if (bus.o_led !== 4'b1000 || bus.o_wrap !== 1'b0 || bus.o_dir !== 1'b0) begin
      fails++; $display("FAIL mc_reload got led=%b wrap=%b dir=%b want 1000 0 0", bus.o_led, bus.o_wrap, bus.o_dir);
    end
    bus.i_shift_enable = 1'b0;
    tick();
    pulse();
    tests++;
    if (bus.o_led !== 4'b0100 || bus.o_wrap !== 1'b0) begin
      fails++; $display("FAIL mc_rotr got led=%b wrap=%b want 0100 0", bus.o_led, bus.o_wrap);
    end
    tick();
  endtask
  task automatic test_freeze();
    bus.i_run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse();
      tick();
      tests++;
      if (bus.o_led !== 4'b0100) begin fails++; $display("FAIL frz_hold%0d got %b want 0100", i, bus.o_led); end
    end
    bus.i_mode = 2'b11;
    tick();
    tests++;
    if (bus.o_led !== 4'b1111) begin fails++; $display("FAIL frz_flash_seed got %b want 1111", bus.o_led); end
    bus.i_run = 1'b1;
    pulse();
    tests++;
    if (bus.o_led !== 4'b0000 || bus.o_wrap !== 1'b0) begin
      fails++; $display("FAIL flash_off got led=%b wrap=%b want 0000 0", bus.o_led, bus.o_wrap);
    end
    tick();
    pulse();
    tests++;
    if (bus.o_led !== 4'b1111 || bus.o_wrap !== 1'b1) begin
      fails++; $display("FAIL flash_on got led=%b wrap=%b want 1111 1", bus.o_led, bus.o_wrap);
    end
    tick();
    tests++;
    if (bus.o_wrap !== 1'b0) begin fails++; $display("FAIL flash_wrap_clear got %b want 0", bus.o_wrap); end
  endtask
  task automatic test_run_fall();
    bus.i_run = 1'b0;
    bus.i_shift_enable = 1'b1;
    tick();
    tests++;
    if (bus.o_led !== 4'b1111) begin fails++; $display("FAIL runfall_nostep got %b want 1111", bus.o_led); end
    bus.i_run = 1'b1;
    tick();
    tests++;
    if (bus.o_led !== 4'b1111) begin fails++; $display("FAIL runfall_noreplay got %b want 1111", bus.o_led); end
    bus.i_shift_enable = 1'b0;
    tick();
    pulse();
    tests++;
    if (bus.o_led !== 4'b0000) begin fails++; $display("FAIL runfall_resume got %b want 0000", bus.o_led); end
    tick();
  endtask
  task automatic test_mid_reset();
    bus.i_mode = 2'b10;
    tick();
    for (int i = 0; i < 3; i++) begin pulse(); tick(); end
    tests++;
    if (bus.o_led !== 4'b1000 || bus.o_dir !== 1'b1) begin
      fails++; $display("FAIL mr_setup got led=%b dir=%b want 1000 1", bus.o_led, bus.o_dir);
    end
    rst = 1'b1;
    bus.i_shift_enable = 1'b1;
    tick();
    tests++;
    if (bus.o_led !== 4'b0001 || bus.o_dir !== 1'b0 || bus.o_wrap !== 1'b0) begin
      fails++; $display("FAIL mr_reset got led=%b dir=%b wrap=%b want 0001 0 0", bus.o_led, bus.o_dir, bus.o_wrap);
    end
    rst = 1'b0;
    bus.i_shift_enable = 1'b0;
    tick();
    tests++;
    if (bus.o_led !== 4'b0001 || bus.o_dir !== 1'b0) begin
      fails++; $display("FAIL mr_reload got led=%b dir=%b want 0001 0", bus.o_led, bus.o_dir);
    end
    for (int i = 0; i < 3; i++) begin pulse(); tick(); end
    tests++;
    if (bus.o_led !== 4'b1000 || bus.o_dir !== 1'b1) begin
      fails++; $display("FAIL mr_pp_mode got led=%b dir=%b want 1000 1", bus.o_led, bus.o_dir);
    end
  endtask
  initial begin
    bus.i_shift_enable = 1'b0;
    bus.i_run = 1'b1;
    bus.i_mode = 2'b00;
    test_reset();
    test_rotate_left();
    test_held_enable();
    test_ping_pong();
    test_mode_change();
    test_freeze();
    test_run_fall();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
